// File: rtl/ld_pkg.sv
// Shared types and defaults for the LD operand sequencer.
package ld_pkg;

  localparam int unsigned LD_ADR_W   = 6;
  localparam int unsigned LD_DATA_W  = 6;
  localparam int unsigned LD_TIMEOUT = 15;
  // Wide enough for any TIMEOUT in 1..63.
  localparam int unsigned LD_CNT_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ1,
    ST_WAIT1,
    ST_REQ2,
    ST_WAIT2,
    ST_DONE,
    ST_HALT
  } ld_state_e;

endpackage

// File: rtl/ld_rd_timer.sv
// Read-response wait counter; expire_c flags the last wait cycle before a re-issue.
module ld_rd_timer
  import ld_pkg::*;
#(
  parameter int unsigned TIMEOUT = LD_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [LD_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + LD_CNT_W'(1);
    end
  end

  assign expire_c = (cnt_q == LD_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ld_operand_sequencer.sv
// Fetches both operands of an instruction with two sequential memory reads,
// then releases the LD register for a single commit cycle; owns sticky halt.
module ld_operand_sequencer
  import ld_pkg::*;
#(
  parameter int unsigned ADR_W   = LD_ADR_W,
  parameter int unsigned DATA_W  = LD_DATA_W,
  parameter int unsigned TIMEOUT = LD_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_halt,
  input  logic [ADR_W-1:0]  in_adr_1,
  input  logic [ADR_W-1:0]  in_adr_2,
  output logic              mem_req,
  output logic [ADR_W-1:0]  mem_adr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ld_freeze,
  output logic              ld_inst_halt,
  output logic              halted_out
);

  ld_state_e        state_q, state_d;
  logic [ADR_W-1:0] adr_1_q, adr_2_q;
  logic             lat_adr, cap_1, cap_2;
  logic             tmr_clr, tmr_en, tmr_expire;

  ld_rd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .expire_c (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      adr_1_q <= '0;
      adr_2_q <= '0;
      data_1  <= '0;
      data_2  <= '0;
    end else begin
      state_q <= state_d;
      if (lat_adr) begin
        adr_1_q <= in_adr_1;
        adr_2_q <= in_adr_2;
      end
      if (cap_1) data_1 <= mem_rdata;
      if (cap_2) data_2 <= mem_rdata;
    end
  end

  // Next state and state-decoded controls; freeze only gates accept, request and commit.
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    mem_req      = 1'b0;
    mem_adr      = '0;
    out_valid    = 1'b0;
    ld_freeze    = 1'b1;
    ld_inst_halt = 1'b0;
    halted_out   = 1'b0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    lat_adr      = 1'b0;
    cap_1        = 1'b0;
    cap_2        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = !freeze;
        if (in_valid && !freeze) begin
          if (in_halt) begin
            state_d = ST_HALT;
          end else begin
            lat_adr = 1'b1;
            state_d = ST_REQ1;
          end
        end
      end
      ST_REQ1: begin
        tmr_clr = 1'b1;
        if (!freeze) begin
          mem_req = 1'b1;
          mem_adr = adr_1_q;
          state_d = ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        if (mem_rvalid) begin
          cap_1   = 1'b1;
          state_d = ST_REQ2;
        end else if (tmr_expire) begin
          state_d = ST_REQ1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_REQ2: begin
        tmr_clr = 1'b1;
        if (!freeze) begin
          mem_req = 1'b1;
          mem_adr = adr_2_q;
          state_d = ST_WAIT2;
        end
      end
      ST_WAIT2: begin
        if (mem_rvalid) begin
          cap_2   = 1'b1;
          state_d = ST_DONE;
        end else if (tmr_expire) begin
          state_d = ST_REQ2;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready && !freeze) begin
          ld_freeze = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_HALT: begin
        halted_out   = 1'b1;
        ld_inst_halt = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ld_operand_sequencer.sv
// Self-checking bench for ld_operand_sequencer: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_ld_operand_sequencer;

  localparam int unsigned TO = 4;

  typedef struct {
    logic       rst, fz, iv, ih;
    logic [5:0] a1, a2;
    logic       rv;
    logic [5:0] rd;
    logic       ordy;
  } in_t;

  typedef struct {
    in_t        i;
    logic       ir, mr;
    logic [5:0] ma;
    logic       ov, lf;
    logic [5:0] d1, d2;
    logic       h;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, freeze, in_valid, in_ready, in_halt;
  logic [5:0] in_adr_1, in_adr_2, mem_adr, mem_rdata, data_1, data_2;
  logic       mem_req, mem_rvalid, out_valid, out_ready;
  logic       ld_freeze, ld_inst_halt, halted_out;

  int n_vec = 0;
  int n_err = 0;

  ld_operand_sequencer #(.ADR_W(6), .DATA_W(6), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_halt      (in_halt),
    .in_adr_1     (in_adr_1),
    .in_adr_2     (in_adr_2),
    .mem_req      (mem_req),
    .mem_adr      (mem_adr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .data_1       (data_1),
    .data_2       (data_2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ld_freeze    (ld_freeze),
    .ld_inst_halt (ld_inst_halt),
    .halted_out   (halted_out)
  );

  always #5 clk = ~clk;

  function automatic in_t I(logic r, logic f, logic v, logic hh, logic [5:0] x1,
                            logic [5:0] x2, logic rvv, logic [5:0] rdd, logic o);
    in_t t;
    t.rst = r; t.fz = f; t.iv = v; t.ih = hh; t.a1 = x1; t.a2 = x2;
    t.rv = rvv; t.rd = rdd; t.ordy = o;
    return t;
  endfunction

  function automatic vec_t V(in_t t, logic ir, logic mr, logic [5:0] ma, logic ov,
                             logic lf, logic [5:0] d1, logic [5:0] d2, logic hh);
    vec_t v;
    v.i = t; v.ir = ir; v.mr = mr; v.ma = ma; v.ov = ov; v.lf = lf;
    v.d1 = d1; v.d2 = d2; v.h = hh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then settle.
  task automatic apply(input in_t t);
    @(negedge clk);
    rst = t.rst; freeze = t.fz; in_valid = t.iv; in_halt = t.ih;
    in_adr_1 = t.a1; in_adr_2 = t.a2; mem_rvalid = t.rv; mem_rdata = t.rd;
    out_ready = t.ordy;
    #1;
  endtask

  task automatic check_all(input vec_t v, input string tag);
    chk({tag, ".in_ready"}, 8'(in_ready), 8'(v.ir));
    chk({tag, ".mem_req"}, 8'(mem_req), 8'(v.mr));
    if (v.mr) chk({tag, ".mem_adr"}, 8'(mem_adr), 8'(v.ma));
    chk({tag, ".out_valid"}, 8'(out_valid), 8'(v.ov));
    chk({tag, ".ld_freeze"}, 8'(ld_freeze), 8'(v.lf));
    chk({tag, ".data_1"}, 8'(data_1), 8'(v.d1));
    chk({tag, ".data_2"}, 8'(data_2), 8'(v.d2));
    chk({tag, ".halted_out"}, 8'(halted_out), 8'(v.h));
    chk({tag, ".ld_inst_halt"}, 8'(ld_inst_halt), 8'(v.h));
  endtask

  task automatic step(input vec_t v, input string tag);
    apply(v.i);
    check_all(v, tag);
  endtask

  in_t  idle_in;
  vec_t tbl[19];

  // Random-phase model state
  logic [5:0] mem_arr[64];
  logic       busy, outstanding, pend;
  int         op, deadline, resp_at, cyc;
  logic [5:0] ca1, ca2, pend_adr, m_d1, m_d2;

  initial begin
    idle_in = I(0, 0, 0, 0, 6'h00, 6'h00, 0, 6'h00, 0);

    // Basic read, backpressure, freeze at IDLE, equal addresses
    tbl[0]  = V(I(0,0,1,0,6'h05,6'h0A,0,6'h00,0), 1,0,6'h00,0,1,6'h00,6'h00,0);
    tbl[1]  = V(idle_in,                         0,1,6'h05,0,1,6'h00,6'h00,0);
    tbl[2]  = V(I(0,0,0,0,6'h00,6'h00,1,6'h11,0), 0,0,6'h00,0,1,6'h00,6'h00,0);
    tbl[3]  = V(idle_in,                         0,1,6'h0A,0,1,6'h11,6'h00,0);
    tbl[4]  = V(I(0,0,0,0,6'h00,6'h00,1,6'h22,0), 0,0,6'h00,0,1,6'h11,6'h00,0);
    tbl[5]  = V(idle_in,                         0,0,6'h00,1,1,6'h11,6'h22,0);
    tbl[6]  = V(idle_in,                         0,0,6'h00,1,1,6'h11,6'h22,0);
    tbl[7]  = V(idle_in,                         0,0,6'h00,1,1,6'h11,6'h22,0);
    tbl[8]  = V(idle_in,                         0,0,6'h00,1,1,6'h11,6'h22,0);
    tbl[9]  = V(I(0,0,0,0,6'h00,6'h00,0,6'h00,1), 0,0,6'h00,1,0,6'h11,6'h22,0);
    tbl[10] = V(I(0,0,0,0,6'h00,6'h00,0,6'h00,1), 1,0,6'h00,0,1,6'h11,6'h22,0);
    tbl[11] = V(I(0,1,1,0,6'h05,6'h0A,0,6'h00,0), 0,0,6'h00,0,1,6'h11,6'h22,0);
    tbl[12] = V(I(0,0,1,0,6'h07,6'h07,0,6'h00,0), 1,0,6'h00,0,1,6'h11,6'h22,0);
    tbl[13] = V(idle_in,                         0,1,6'h07,0,1,6'h11,6'h22,0);
    tbl[14] = V(I(0,0,0,0,6'h00,6'h00,1,6'h33,0), 0,0,6'h00,0,1,6'h11,6'h22,0);
    tbl[15] = V(idle_in,                         0,1,6'h07,0,1,6'h33,6'h22,0);
    tbl[16] = V(I(0,0,0,0,6'h00,6'h00,1,6'h3C,0), 0,0,6'h00,0,1,6'h33,6'h22,0);
    tbl[17] = V(I(0,0,0,0,6'h00,6'h00,0,6'h00,1), 0,0,6'h00,1,0,6'h33,6'h3C,0);
    tbl[18] = V(idle_in,                         1,0,6'h00,0,1,6'h33,6'h3C,0);

    apply(I(1, 0, 0, 0, 6'h00, 6'h00, 0, 6'h00, 0));
    apply(I(1, 0, 0, 0, 6'h00, 6'h00, 0, 6'h00, 0));
    for (int k = 0; k < 19; k++) step(tbl[k], $sformatf("tbl%0d", k));

    // Timeout re-issue every TO+1 cycles; a late rvalid in REQ1 is ignored
    step(V(I(0,0,1,0,6'h05,6'h0A,0,6'h00,0), 1,0,6'h00,0,1,6'h33,6'h3C,0), "to0");
    for (int k = 1; k <= 11; k++) begin
      logic req_here;
      req_here = (k == 1) || (k == 6) || (k == 11);
      step(V(I(0,0,0,0,6'h00,6'h00,(k == 6),6'h3F,0), 0,req_here,6'h05,0,1,6'h33,6'h3C,0),
           $sformatf("to%0d", k));
    end
    step(V(I(0,0,0,0,6'h00,6'h00,1,6'h2A,0), 0,0,6'h00,0,1,6'h33,6'h3C,0), "to12");
    step(V(idle_in,                         0,1,6'h0A,0,1,6'h2A,6'h3C,0), "to13");
    step(V(I(0,0,0,0,6'h00,6'h00,1,6'h15,0), 0,0,6'h00,0,1,6'h2A,6'h3C,0), "to14");
    step(V(I(0,0,0,0,6'h00,6'h00,0,6'h00,1), 0,0,6'h00,1,0,6'h2A,6'h15,0), "to15");
    step(V(idle_in,                         1,0,6'h00,0,1,6'h2A,6'h15,0), "to16");

    // Freeze holds requests and commit but not capture
    step(V(I(0,0,1,0,6'h01,6'h02,0,6'h00,0), 1,0,6'h00,0,1,6'h2A,6'h15,0), "fz0");
    step(V(I(0,1,0,0,6'h00,6'h00,0,6'h00,0), 0,0,6'h00,0,1,6'h2A,6'h15,0), "fz1");
    step(V(idle_in,                         0,1,6'h01,0,1,6'h2A,6'h15,0), "fz2");
    step(V(I(0,1,0,0,6'h00,6'h00,1,6'h0C,0), 0,0,6'h00,0,1,6'h2A,6'h15,0), "fz3");
    step(V(I(0,1,0,0,6'h00,6'h00,0,6'h00,0), 0,0,6'h00,0,1,6'h0C,6'h15,0), "fz4");
    step(V(I(0,1,0,0,6'h00,6'h00,0,6'h00,0), 0,0,6'h00,0,1,6'h0C,6'h15,0), "fz5");
    step(V(idle_in,                         0,1,6'h02,0,1,6'h0C,6'h15,0), "fz6");
    step(V(I(0,0,0,0,6'h00,6'h00,1,6'h30,0), 0,0,6'h00,0,1,6'h0C,6'h15,0), "fz7");
    step(V(I(0,1,0,0,6'h00,6'h00,0,6'h00,1), 0,0,6'h00,1,1,6'h0C,6'h30,0), "fz8");
    step(V(I(0,0,0,0,6'h00,6'h00,0,6'h00,1), 0,0,6'h00,1,0,6'h0C,6'h30,0), "fz9");
    step(V(I(0,1,0,0,6'h00,6'h00,0,6'h00,0), 0,0,6'h00,0,1,6'h0C,6'h30,0), "fz10");

    // Reset in WAIT2, then a stale response must be ignored
    step(V(I(0,0,1,0,6'h09,6'h0B,0,6'h00,0), 1,0,6'h00,0,1,6'h0C,6'h30,0), "rs0");
    step(V(idle_in,                         0,1,6'h09,0,1,6'h0C,6'h30,0), "rs1");
    step(V(I(0,0,0,0,6'h00,6'h00,1,6'h1E,0), 0,0,6'h00,0,1,6'h0C,6'h30,0), "rs2");
    step(V(idle_in,                         0,1,6'h0B,0,1,6'h1E,6'h30,0), "rs3");
    step(V(I(1,0,0,0,6'h00,6'h00,0,6'h00,0), 0,0,6'h00,0,1,6'h1E,6'h30,0), "rs4");
    step(V(I(0,0,0,0,6'h00,6'h00,1,6'h3F,0), 1,0,6'h00,0,1,6'h00,6'h00,0), "rs5");
    step(V(idle_in,                         1,0,6'h00,0,1,6'h00,6'h00,0), "rs6");

    // Randomized run against a transaction-level model
    for (int k = 0; k < 64; k++) mem_arr[k] = 6'($urandom);
    busy = 0; outstanding = 0; pend = 0; op = 0; deadline = 0; resp_at = 0;
    ca1 = '0; ca2 = '0; pend_adr = '0; m_d1 = '0; m_d2 = '0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      in_t  t;
      vec_t v;
      t.rst  = 0;
      t.fz   = ($urandom_range(0, 9) < 2);
      t.iv   = ($urandom_range(0, 1) == 1);
      t.ih   = 0;
      t.a1   = 6'($urandom);
      t.a2   = ($urandom_range(0, 7) == 0) ? t.a1 : 6'($urandom);
      t.rv   = pend && (resp_at == cyc);
      t.rd   = t.rv ? mem_arr[pend_adr] : 6'($urandom);
      t.ordy = ($urandom_range(0, 9) < 6);
      v.i  = t;
      v.ir = !busy && !t.fz;
      v.mr = busy && (op < 3) && !outstanding && !t.fz;
      v.ma = (op == 1) ? ca1 : ca2;
      v.ov = busy && (op == 3);
      v.lf = !(v.ov && t.ordy && !t.fz);
      v.d1 = m_d1;
      v.d2 = m_d2;
      v.h  = 0;
      step(v, "rnd");
      if (v.mr) begin
        outstanding = 1;
        deadline    = cyc + int'(TO);
        if ($urandom_range(0, 9) != 0) begin
          pend     = 1;
          resp_at  = cyc + int'($urandom_range(1, TO));
          pend_adr = v.ma;
        end
      end else if (outstanding) begin
        if (t.rv) begin
          if (op == 1) m_d1 = t.rd;
          else         m_d2 = t.rd;
          op++;
          outstanding = 0;
          pend        = 0;
        end else if (cyc == deadline) begin
          outstanding = 0;
        end
      end
      if (v.ir && t.iv) begin
        busy = 1; op = 1; outstanding = 0; ca1 = t.a1; ca2 = t.a2;
      end
      if (v.ov && t.ordy && !t.fz) busy = 0;
    end

    // Sticky halt, cleared only by reset
    apply(I(1, 0, 0, 0, 6'h00, 6'h00, 0, 6'h00, 0));
    step(V(I(0,0,1,1,6'h05,6'h0A,0,6'h00,0), 1,0,6'h00,0,1,6'h00,6'h00,0), "h0");
    for (int k = 1; k <= 5; k++)
      step(V(I(0,(k == 3),1,(k == 4),6'h05,6'h0A,(k == 2),6'h2B,1), 0,0,6'h00,0,1,6'h00,6'h00,1),
           $sformatf("h%0d", k));
    step(V(I(1,0,0,0,6'h00,6'h00,0,6'h00,0), 0,0,6'h00,0,1,6'h00,6'h00,1), "h6");
    step(V(I(0,0,1,0,6'h05,6'h0A,0,6'h00,0), 1,0,6'h00,0,1,6'h00,6'h00,0), "h7");
    step(V(idle_in,                         0,1,6'h05,0,1,6'h00,6'h00,0), "h8");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
